// File: rtl/uart_hex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_hex_pkg
// Description : Shared types, divider helper and seven-segment table for the
//               UART hex display.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_hex_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Active-low segment patterns {g,f,e,d,c,b,a} for digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Rounded clock cycles per bit; clk_freq is in MHz.
    function automatic int bit_cycles(input int clk_freq, input int bit_rate);
        longint num;
        num = longint'(clk_freq) * 64'sd1000000 + longint'(bit_rate / 2);
        return int'(num / longint'(bit_rate));
    endfunction

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 UART receiver with two-flop input synchronizer and
//               mid-bit sampling; emits one-cycle byte_valid per good frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_hex_pkg::*;
#(
    parameter int CLK_FREQ = 50,
    parameter int BIT_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] data
);

    localparam int BIT_CYCLES  = bit_cycles(CLK_FREQ, BIT_RATE);
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    rx_state_t        r_state;
    rx_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_frame_err;
    logic             r_valid;
    logic [7:0]       r_data;

    logic w_rx;
    logic w_bit_done;
    logic w_half_done;
    logic w_cnt_clr;
    logic w_sample;
    logic w_accept;
    logic w_frame_err_set;

    assign w_rx        = r_sync2;
    assign w_bit_done  = (r_cnt == BIT_LAST);
    assign w_half_done = (r_cnt == HALF_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= IDLE;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_clr       = 1'b0;
        w_sample        = 1'b0;
        w_accept        = 1'b0;
        w_frame_err_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx) begin
                    w_state_next = START;
                    w_cnt_clr    = 1'b1;
                end
            end
            START: begin
                if (w_half_done) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = w_rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_cnt_clr = 1'b1;
                    w_sample  = 1'b1;
                    if (r_idx == 3'd7) begin
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Counter parks at BIT_LAST so a framing error waits for idle.
                if (w_bit_done) begin
                    if (w_rx) begin
                        w_state_next = IDLE;
                        w_cnt_clr    = 1'b1;
                        w_accept     = !r_frame_err;
                    end else begin
                        w_frame_err_set = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_frame_err <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= 8'h00;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_data <= r_shift;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_state != IDLE && !(r_state == STOP && w_bit_done)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_sample) begin
                r_shift <= {w_rx, r_shift[7:1]};
                r_idx   <= r_idx + 3'd1;
            end
            if (w_frame_err_set) begin
                r_frame_err <= 1'b1;
            end else if (r_state != STOP) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign byte_valid = r_valid;
    assign data       = r_data;

endmodule
`default_nettype wire

// File: rtl/uart_hex_display.sv
`default_nettype none
// ============================================================================
// Module      : uart_hex_display
// Description : Shows the last two received UART bytes as four hex digits on
//               active-low seven-segment displays.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_hex_display
    import uart_hex_pkg::*;
#(
    parameter int CLK_FREQ = 50,
    parameter int BIT_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3
);

    logic            w_byte_valid;
    logic [7:0]      w_byte;
    logic [15:0]     r_history;
    logic [3:0][6:0] r_seg;

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BIT_RATE (BIT_RATE)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .byte_valid (w_byte_valid),
        .data       (w_byte)
    );

    // Newest byte lands in the low half so hex1/hex0 always show it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_history <= 16'h0000;
        end else if (w_byte_valid) begin
            r_history <= {r_history[7:0], w_byte};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_seg[i] <= SEG_TABLE[0];
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_seg[i] <= hex_to_seg(r_history[4*i +: 4]);
            end
        end
    end

    assign hex0 = r_seg[0];
    assign hex1 = r_seg[1];
    assign hex2 = r_seg[2];
    assign hex3 = r_seg[3];

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_display.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_hex_display
// Description : Directed and random-frame bench for uart_hex_display with a
//               display-value scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_hex_display;

    localparam int CLK_FREQ = 50;
    localparam int BIT_RATE = 1562500;   // 32 clocks per bit
    localparam int CLK_NS   = 20;
    localparam int BIT_NS   = 640;
    localparam int FAST_NS  = 627;       // about +2 % bit rate
    localparam int SLOW_NS  = 653;       // about -2 % bit rate

    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic [27:0] shown;

    typedef struct {
        string       tag;
        logic [27:0] disp;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] model_hist;

    uart_hex_display #(
        .CLK_FREQ (CLK_FREQ),
        .BIT_RATE (BIT_RATE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (uart_rx),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3)
    );

    always #(CLK_NS/2) clk = ~clk;

    assign shown = {hex3, hex2, hex1, hex0};

    function automatic logic [27:0] disp_of(input logic [15:0] h);
        return {SEG[h[15:12]], SEG[h[11:8]], SEG[h[7:4]], SEG[h[3:0]]};
    endfunction

    task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] b);
        exp_t e;
        model_hist = {model_hist[7:0], b};
        e.tag  = tag;
        e.disp = disp_of(model_hist);
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check(e.tag, shown, e.disp);
        end
    endtask

    // Early check lands 6 clocks after the stop-bit midpoint.
    task automatic send_byte(input logic [7:0] d, input logic stop, input int period,
                             input bit early);
        @(negedge clk);
        uart_rx = 1'b0;
        #(period);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            #(period);
        end
        uart_rx = stop;
        if (early) begin
            #(period/2 + 6*CLK_NS);
            sb_check();
            #(period - period/2 - 6*CLK_NS);
        end else begin
            #(period);
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] partial;
        int         gap;
        int         sel;
        int         period;

        reset      = 1'b1;
        uart_rx    = 1'b1;
        model_hist = 16'h0000;
        #300;
        @(negedge clk);
        reset = 1'b0;

        check("reset_state", shown, {7'h40, 7'h40, 7'h40, 7'h40});
        for (int i = 0; i < 10; i++) begin
            repeat (200) @(negedge clk);
            check("idle_hold", shown, {7'h40, 7'h40, 7'h40, 7'h40});
        end

        expect_byte("byte_a5", 8'hA5);
        send_byte(8'hA5, 1'b1, BIT_NS, 1'b1);
        check("a5_digits", shown, {7'h40, 7'h40, 7'h08, 7'h12});

        expect_byte("byte_3c", 8'h3C);
        send_byte(8'h3C, 1'b1, BIT_NS, 1'b1);
        check("3c_digits", shown, {7'h08, 7'h12, 7'h30, 7'h46});

        repeat (20) @(negedge clk);
        uart_rx = 1'b0;
        repeat (8) @(negedge clk);
        uart_rx = 1'b1;
        repeat (64) @(negedge clk);
        check("glitch", shown, {7'h08, 7'h12, 7'h30, 7'h46});

        expect_byte("byte_7e", 8'h7E);
        send_byte(8'h7E, 1'b1, BIT_NS, 1'b1);
        check("7e_digits", shown, {7'h30, 7'h46, 7'h78, 7'h06});

        send_byte(8'h55, 1'b0, BIT_NS, 1'b0);
        #(BIT_NS);
        check("framing_err", shown, {7'h30, 7'h46, 7'h78, 7'h06});

        expect_byte("byte_f0", 8'hF0);
        send_byte(8'hF0, 1'b1, BIT_NS, 1'b1);
        check("f0_digits", shown, {7'h78, 7'h06, 7'h0E, 7'h40});

        // Abort a frame with reset in the middle of bit 4.
        partial = 8'hC9;
        @(negedge clk);
        uart_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            uart_rx = partial[i];
            #(BIT_NS);
        end
        uart_rx = partial[4];
        #(BIT_NS/2);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        uart_rx = 1'b1;
        model_hist = 16'h0000;
        repeat (64) @(negedge clk);
        check("mid_reset", shown, {7'h40, 7'h40, 7'h40, 7'h40});

        expect_byte("byte_12", 8'h12);
        send_byte(8'h12, 1'b1, BIT_NS, 1'b1);
        check("12_digits", shown, {7'h40, 7'h40, 7'h79, 7'h24});

        for (int i = 0; i < 10; i++) begin
            b   = 8'($urandom_range(0, 255));
            gap = (i < 2) ? 0 : int'($urandom_range(0, 30));
            sel = (i < 2) ? 1 : int'($urandom_range(0, 2));
            period = (sel == 0) ? FAST_NS : ((sel == 1) ? BIT_NS : SLOW_NS);
            if (gap > 0) begin
                #(gap * BIT_NS);
            end
            expect_byte($sformatf("rand%0d_%02h_p%0d", i, b, period), b);
            send_byte(b, 1'b1, period, period == BIT_NS);
            if (period != BIT_NS) begin
                repeat (2) @(negedge clk);
                sb_check();
            end
        end

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drained: observed %0d entries expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
